obj_line_buffer_pingpong: RTL and testbench

//  Parametrised ping-pong OBJ line buffer for the PPU object pipeline.
//  The sprite renderer writes pixels for line N+1 into one bank while the compositor reads line N from the other.

---
 rtl/obj_line_buffer_pingpong_if.sv | 43 ++++
 rtl/obj_line_buffer_pingpong.sv | 167 ++++++++++++++++
 tb/tb_obj_line_buffer_pingpong.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/obj_line_buffer_pingpong_if.sv
// obj_line_buffer_pingpong_if
//   Bundles the sprite-renderer write side, the compositor read side and the
//   line control/status signals of the OBJ ping-pong line buffer.
//   master : renderer/compositor side (drives requests, sees ready/data/busy)
//   slave  : line buffer side
// Signals
//   line_start  1-cycle pulse: swap banks and clear the new write bank
//   wr_valid / wr_ready, wr_col, wr_color, wr_prio, wr_semi, wr_transp, wr_window
//   rd_en, rd_col -> rd_valid, rd_data {opaque, prio, semi, color}, rd_win
//   busy        clear engine active
interface obj_line_buffer_pingpong_if #(
  parameter int COL_W   = 8,
  parameter int COLOR_W = 16,
  parameter int PRIO_W  = 2
);
  logic                        line_start;
  logic                        wr_valid;
  logic                        wr_ready;
  logic [COL_W-1:0]            wr_col;
  logic [COLOR_W-1:0]          wr_color;
  logic [PRIO_W-1:0]           wr_prio;
  logic                        wr_semi;
  logic                        wr_transp;
  logic                        wr_window;
  logic                        rd_en;
  logic [COL_W-1:0]            rd_col;
  logic                        rd_valid;
  logic [2+PRIO_W+COLOR_W-1:0] rd_data;
  logic                        rd_win;
  logic                        busy;

  modport master (
    output line_start, wr_valid, wr_col, wr_color, wr_prio, wr_semi,
           wr_transp, wr_window, rd_en, rd_col,
    input  wr_ready, rd_valid, rd_data, rd_win, busy
  );

  modport slave (
    input  line_start, wr_valid, wr_col, wr_color, wr_prio, wr_semi,
           wr_transp, wr_window, rd_en, rd_col,
    output wr_ready, rd_valid, rd_data, rd_win, busy
  );
endinterface

// File: rtl/obj_line_buffer_pingpong.sv
// obj_line_buffer_pingpong
//   Ping-pong OBJ line buffer. The sprite renderer builds line N+1 in the write
//   bank (bank_sel) while the compositor reads line N from the other bank.
//   Writes resolve per-pixel priority (lower value wins, first writer wins on a
//   tie), transparency and the OBJ-window bit. A sequential clear engine zeroes
//   one entry per cycle after each bank swap; reads are registered.
// Ports
//   clock  system clock
//   reset  asynchronous, active-low reset
//   bus    obj_line_buffer_pingpong_if.slave (write, read, line control, busy)
//
// state      | meaning
// -----------+-----------------------------------------------------------
// CLR_BOTH   | post-reset: zero entry ptr in both banks, busy
// CLR        | zero entry ptr of the write bank, busy
// IDLE       | clear done, pixel writes accepted
module obj_line_buffer_pingpong #(
  parameter int LINE_W  = 240,
  parameter int COL_W   = 8,
  parameter int COLOR_W = 16,
  parameter int PRIO_W  = 2
) (
  input  logic                        clock,
  input  logic                        reset,
  obj_line_buffer_pingpong_if.slave   bus
);

  // entry layout: {opaque, prio, semi, color, win}
  localparam int ENTRY_W = 3 + PRIO_W + COLOR_W;
  localparam logic [COL_W:0]   LINE_LEN = (COL_W+1)'(LINE_W);
  localparam logic [COL_W-1:0] PTR_LAST = COL_W'(LINE_W - 1);

  typedef enum logic [1:0] {
    S_CLR_BOTH = 2'd0,
    S_CLR      = 2'd1,
    S_IDLE     = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [COL_W-1:0] ptr, ptr_nx;
  logic             bank_sel, bank_sel_nx;

  logic             clr_both, clr_one, wr_ready_int;

  logic [ENTRY_W-1:0] mem [2][LINE_W];

  logic               wr_in_range, rd_in_range;
  logic [ENTRY_W-1:0] cur_entry, wr_entry, rd_entry;
  logic               cur_opaque;
  logic [PRIO_W-1:0]  cur_prio;
  logic               wr_we;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= S_CLR_BOTH;
      ptr      <= '0;
      bank_sel <= 1'b0;
    end else begin
      state    <= state_nx;
      ptr      <= ptr_nx;
      bank_sel <= bank_sel_nx;
    end
  end

  // ---------------- FSM: next state ----------------
  // line_start wins from any state, restarting the clear on the new write bank.
  always_comb begin
    state_nx    = state;
    ptr_nx      = ptr;
    bank_sel_nx = bank_sel;
    if (bus.line_start) begin
      bank_sel_nx = ~bank_sel;
      ptr_nx      = '0;
      state_nx    = S_CLR;
    end else begin
      case (state)
        S_CLR_BOTH, S_CLR: begin
          if (ptr == PTR_LAST) begin
            ptr_nx   = '0;
            state_nx = S_IDLE;
          end else begin
            ptr_nx = ptr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    clr_both     = 1'b0;
    clr_one      = 1'b0;
    wr_ready_int = 1'b0;
    case (state)
      S_CLR_BOTH: clr_both     = 1'b1;
      S_CLR:      clr_one      = 1'b1;
      S_IDLE:     wr_ready_int = 1'b1;
      default:    ;
    endcase
  end

  assign bus.wr_ready = wr_ready_int;
  assign bus.busy     = ~wr_ready_int;

  // ---------------- write resolution ----------------
  assign wr_in_range = ({1'b0, bus.wr_col} < LINE_LEN);
  assign rd_in_range = ({1'b0, bus.rd_col} < LINE_LEN);

  assign cur_entry  = mem[bank_sel][bus.wr_col];
  assign cur_opaque = cur_entry[ENTRY_W-1];
  assign cur_prio   = cur_entry[ENTRY_W-2 -: PRIO_W];

  // Window sprites only mark coverage; they never touch the colour fields.
  // Strict less-than keeps the earlier (lower OAM index) pixel on a tie.
  always_comb begin
    wr_we    = 1'b0;
    wr_entry = cur_entry;
    if (bus.wr_valid && wr_ready_int && wr_in_range) begin
      if (bus.wr_window) begin
        wr_we       = 1'b1;
        wr_entry[0] = 1'b1;
      end else if (!bus.wr_transp && (!cur_opaque || (bus.wr_prio < cur_prio))) begin
        wr_we    = 1'b1;
        wr_entry = {1'b1, bus.wr_prio, bus.wr_semi, bus.wr_color, cur_entry[0]};
      end
    end
  end

  // Clear and pixel writes never coincide: writes are only accepted in IDLE.
  always_ff @(posedge clock) begin
    if (clr_both) begin
      mem[1'b0][ptr] <= '0;
      mem[1'b1][ptr] <= '0;
    end else if (clr_one) begin
      mem[bank_sel][ptr] <= '0;
    end
    if (wr_we) begin
      mem[bank_sel][bus.wr_col] <= wr_entry;
    end
  end

  // ---------------- registered read port ----------------
  // Uses the current (pre-toggle) read bank even in a line_start cycle.
  always_comb begin
    rd_entry = '0;
    if (rd_in_range) begin
      rd_entry = mem[~bank_sel][bus.rd_col];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus.rd_valid <= 1'b0;
      bus.rd_data  <= '0;
      bus.rd_win   <= 1'b0;
    end else begin
      bus.rd_valid <= bus.rd_en;
      if (bus.rd_en) begin
        bus.rd_data <= rd_entry[ENTRY_W-1:1];
        bus.rd_win  <= rd_entry[0];
      end
    end
  end

endmodule

// File: tb/tb_obj_line_buffer_pingpong.sv
module tb_obj_line_buffer_pingpong;
  localparam int LINE_W  = 240;
  localparam int COL_W   = 8;
  localparam int COLOR_W = 16;
  localparam int PRIO_W  = 2;
  localparam int DATA_W  = 2 + PRIO_W + COLOR_W;

  logic clock = 1'b0;
  logic reset = 1'b0;

  obj_line_buffer_pingpong_if #(.COL_W(COL_W), .COLOR_W(COLOR_W), .PRIO_W(PRIO_W)) bus ();

  obj_line_buffer_pingpong #(
    .LINE_W(LINE_W), .COL_W(COL_W), .COLOR_W(COLOR_W), .PRIO_W(PRIO_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  // reference model: two banks of pixels, write bank index m_wsel
  typedef struct {
    bit opaque;
    int prio;
    bit semi;
    int color;
    bit win;
  } pix_t;

  pix_t model [2][LINE_W];
  int   m_wsel = 0;

  function automatic void model_clear(int b, int first, int last);
    for (int c = first; c <= last; c++) model[b][c] = '{0, 0, 0, 0, 0};
  endfunction

  function automatic void model_write(int col, int color, int prio, bit semi,
                                      bit transp, bit window);
    if (col >= LINE_W) return;
    if (window) begin
      model[m_wsel][col].win = 1;
    end else if (!transp && (!model[m_wsel][col].opaque || prio < model[m_wsel][col].prio)) begin
      model[m_wsel][col].opaque = 1;
      model[m_wsel][col].prio   = prio;
      model[m_wsel][col].semi   = semi;
      model[m_wsel][col].color  = color;
    end
  endfunction

  function automatic logic [DATA_W-1:0] model_rd_data(int col);
    pix_t p;
    if (col >= LINE_W) return '0;
    p = model[1 - m_wsel][col];
    return {p.opaque, PRIO_W'(p.prio), p.semi, COLOR_W'(p.color)};
  endfunction

  function automatic logic model_rd_win(int col);
    if (col >= LINE_W) return 1'b0;
    return model[1 - m_wsel][col].win;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.line_start = 0;
    bus.wr_valid   = 0;
    bus.wr_col     = '0;
    bus.wr_color   = '0;
    bus.wr_prio    = '0;
    bus.wr_semi    = 0;
    bus.wr_transp  = 0;
    bus.wr_window  = 0;
    bus.rd_en      = 0;
    bus.rd_col     = '0;
  endtask

  task automatic do_write(int col, int color, int prio, bit semi, bit transp, bit window);
    bus.wr_valid  = 1;
    bus.wr_col    = COL_W'(col);
    bus.wr_color  = COLOR_W'(color);
    bus.wr_prio   = PRIO_W'(prio);
    bus.wr_semi   = semi;
    bus.wr_transp = transp;
    bus.wr_window = window;
    step();
    model_write(col, color, prio, semi, transp, window);
    bus.wr_valid  = 0;
    bus.wr_window = 0;
    bus.wr_transp = 0;
  endtask

  task automatic do_read(int col, output logic [DATA_W-1:0] data, output logic win,
                         output logic valid);
    bus.rd_en  = 1;
    bus.rd_col = COL_W'(col);
    step();
    bus.rd_en = 0;
    data  = bus.rd_data;
    win   = bus.rd_win;
    valid = bus.rd_valid;
  endtask

  // waits for the clear engine; returns busy cycles and whether wr_ready was seen high
  task automatic wait_clear(output int n, output bit rdy_seen);
    n = 0;
    rdy_seen = 0;
    while (bus.busy && n < 2000) begin
      if (bus.wr_ready) rdy_seen = 1;
      step();
      n++;
    end
  endtask

  task automatic do_swap(output int n, output bit rdy_seen);
    bus.line_start = 1;
    step();
    bus.line_start = 0;
    m_wsel = 1 - m_wsel;
    wait_clear(n, rdy_seen);
    model_clear(m_wsel, 0, LINE_W - 1);
  endtask

  task automatic test_reset();
    logic [DATA_W-1:0] d;
    logic w, v;
    int n;
    bit rdy;
    int errs;
    reset = 0;
    idle_inputs();
    repeat (3) step();
    n_cmp++;
    if (bus.wr_ready !== 1'b0 || bus.busy !== 1'b1 || bus.rd_valid !== 1'b0 ||
        bus.rd_data !== '0 || bus.rd_win !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: wr_ready=%b busy=%b rd_valid=%b rd_data=%h rd_win=%b, want 0 1 0 0 0",
               bus.wr_ready, bus.busy, bus.rd_valid, bus.rd_data, bus.rd_win);
    end
    reset = 1;
    model_clear(0, 0, LINE_W - 1);
    model_clear(1, 0, LINE_W - 1);
    m_wsel = 0;
    wait_clear(n, rdy);
    n_cmp++;
    if (n !== LINE_W || rdy) begin
      n_err++;
      $display("FAIL reset_clear_len: busy_cycles=%0d wr_ready_seen=%0d, want %0d 0", n, rdy, LINE_W);
    end
    do_swap(n, rdy);
    n_cmp++;
    if (n !== LINE_W) begin
      n_err++;
      $display("FAIL reset_swap_len: busy_cycles=%0d, want %0d", n, LINE_W);
    end
    errs = 0;
    for (int c = 0; c < LINE_W; c++) begin
      do_read(c, d, w, v);
      n_cmp++;
      if (d !== '0 || w !== 1'b0 || v !== 1'b1) begin
        n_err++;
        errs++;
        if (errs < 5) $display("FAIL reset_bank_zero col=%0d: data=%h win=%b valid=%b, want 0 0 1", c, d, w, v);
      end
    end
  endtask

  task automatic test_priority();
    logic [DATA_W-1:0] d;
    logic w, v;
    int n;
    bit rdy;
    do_write(5, 16'h1234, 2, 0, 0, 0);
    do_write(5, 16'h00FF, 1, 0, 0, 0);
    do_write(5, 16'h0F0F, 1, 1, 0, 0);
    do_swap(n, rdy);
    do_read(5, d, w, v);
    n_cmp++;
    if (d !== 20'hA00FF || w !== 1'b0 || v !== 1'b1) begin
      n_err++;
      $display("FAIL priority_col5: data=%h win=%b valid=%b, want a00ff 0 1", d, w, v);
    end
  endtask

  task automatic test_transp_window();
    logic [DATA_W-1:0] d;
    logic w, v;
    int n;
    bit rdy;
    do_write(7, 16'h7FFF, 0, 0, 1, 0);
    do_swap(n, rdy);
    do_read(7, d, w, v);
    n_cmp++;
    if (d !== '0 || w !== 1'b0) begin
      n_err++;
      $display("FAIL transparent_col7: data=%h win=%b, want 0 0", d, w);
    end
    do_write(7, 16'h5555, 0, 1, 0, 1);
    do_swap(n, rdy);
    do_read(7, d, w, v);
    n_cmp++;
    if (d !== '0 || w !== 1'b1) begin
      n_err++;
      $display("FAIL window_col7: data=%h win=%b, want 0 1", d, w);
    end
  endtask

  task automatic test_read_timing();
    logic [DATA_W-1:0] exp_d;
    int n;
    bit rdy;
    do_write(10, 16'hBEEF, 3, 1, 0, 0);
    do_write(10, 16'h0001, 0, 0, 0, 1);
    do_swap(n, rdy);
    exp_d = model_rd_data(10);
    bus.rd_en  = 1;
    bus.rd_col = 8'd10;
    #2;
    n_cmp++;
    if (bus.rd_valid !== 1'b0) begin
      n_err++;
      $display("FAIL read_latency_early: rd_valid=%b, want 0", bus.rd_valid);
    end
    step();
    n_cmp++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp_d || bus.rd_win !== 1'b1) begin
      n_err++;
      $display("FAIL read_col10: valid=%b data=%h win=%b, want 1 %h 1", bus.rd_valid, bus.rd_data, bus.rd_win, exp_d);
    end
    bus.rd_col = 8'd240;
    step();
    n_cmp++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== '0 || bus.rd_win !== 1'b0) begin
      n_err++;
      $display("FAIL read_col240: valid=%b data=%h win=%b, want 1 0 0", bus.rd_valid, bus.rd_data, bus.rd_win);
    end
    bus.rd_col = 8'd10;
    step();
    bus.rd_col = 8'd255;
    step();
    n_cmp++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== '0 || bus.rd_win !== 1'b0) begin
      n_err++;
      $display("FAIL read_col255: valid=%b data=%h win=%b, want 1 0 0", bus.rd_valid, bus.rd_data, bus.rd_win);
    end
    bus.rd_col = 8'd10;
    step();
    bus.rd_en  = 0;
    bus.rd_col = 8'd3;
    step();
    n_cmp++;
    if (bus.rd_valid !== 1'b0 || bus.rd_data !== exp_d || bus.rd_win !== 1'b1) begin
      n_err++;
      $display("FAIL read_hold: valid=%b data=%h win=%b, want 0 %h 1", bus.rd_valid, bus.rd_data, bus.rd_win, exp_d);
    end
  endtask

  task automatic test_abort();
    logic [DATA_W-1:0] d;
    logic w, v;
    int n;
    bit rdy, busy_drop;
    int wbank;
    do_write(50, 16'h1111, 0, 0, 0, 0);
    do_write(200, 16'h2222, 3, 1, 0, 0);
    wbank = m_wsel;
    do_swap(n, rdy);
    bus.line_start = 1;
    step();
    bus.line_start = 0;
    m_wsel = 1 - m_wsel;
    busy_drop = 0;
    rdy = 0;
    for (int i = 0; i < 100; i++) begin
      if (!bus.busy) busy_drop = 1;
      if (bus.wr_ready) rdy = 1;
      step();
    end
    bus.line_start = 1;
    step();
    bus.line_start = 0;
    m_wsel = 1 - m_wsel;
    model_clear(wbank, 0, 99);
    n_cmp++;
    if (busy_drop || rdy) begin
      n_err++;
      $display("FAIL abort_pre_busy: busy_dropped=%0d wr_ready_seen=%0d, want 0 0", busy_drop, rdy);
    end
    wait_clear(n, rdy);
    model_clear(m_wsel, 0, LINE_W - 1);
    n_cmp++;
    if (n !== LINE_W || rdy) begin
      n_err++;
      $display("FAIL abort_clear_len: busy_cycles=%0d wr_ready_seen=%0d, want %0d 0", n, rdy, LINE_W);
    end
    do_read(50, d, w, v);
    n_cmp++;
    if (d !== model_rd_data(50) || d !== '0) begin
      n_err++;
      $display("FAIL abort_col50: data=%h, want 0", d);
    end
    do_read(200, d, w, v);
    n_cmp++;
    if (d !== model_rd_data(200) || d !== 20'hF2222) begin
      n_err++;
      $display("FAIL abort_col200: data=%h, want f2222", d);
    end
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] d, exp_old;
    logic w, v;
    int n;
    bit rdy;
    do_write(3, 16'h0AAA, 2, 0, 0, 0);
    do_swap(n, rdy);
    exp_old = model_rd_data(3);
    n_cmp++;
    if (bus.wr_ready !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_ready_before: wr_ready=%b, want 1", bus.wr_ready);
    end
    bus.wr_valid   = 1;
    bus.wr_col     = 8'd3;
    bus.wr_color   = 16'h0BBB;
    bus.wr_prio    = 2'd1;
    bus.wr_semi    = 1;
    bus.line_start = 1;
    bus.rd_en      = 1;
    bus.rd_col     = 8'd3;
    step();
    model_write(3, 16'h0BBB, 1, 1, 0, 0);
    bus.wr_valid   = 0;
    bus.line_start = 0;
    bus.rd_en      = 0;
    m_wsel = 1 - m_wsel;
    n_cmp++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp_old || bus.wr_ready !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_swap_cycle: valid=%b data=%h wr_ready=%b, want 1 %h 0",
               bus.rd_valid, bus.rd_data, bus.wr_ready, exp_old);
    end
    wait_clear(n, rdy);
    model_clear(m_wsel, 0, LINE_W - 1);
    do_read(3, d, w, v);
    n_cmp++;
    if (d !== model_rd_data(3) || d !== 20'hB0BBB) begin
      n_err++;
      $display("FAIL b2b_col3_new: data=%h, want b0bbb", d);
    end
    do_swap(n, rdy);
    do_read(3, d, w, v);
    n_cmp++;
    if (d !== '0 || w !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_col3_cleared: data=%h win=%b, want 0 0", d, w);
    end
  endtask

  task automatic test_random();
    logic [DATA_W-1:0] d;
    logic w, v;
    int n;
    bit rdy;
    int col, errs;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 80; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          step();
        end else begin
          col = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 15);
          do_write(col, $urandom_range(0, 16'hFFFF), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
        end
      end
      do_swap(n, rdy);
      n_cmp++;
      if (n !== LINE_W) begin
        n_err++;
        $display("FAIL random_swap_len round=%0d: busy_cycles=%0d, want %0d", r, n, LINE_W);
      end
      errs = 0;
      for (int c = 0; c < 256; c++) begin
        do_read(c, d, w, v);
        n_cmp++;
        if (d !== model_rd_data(c) || w !== model_rd_win(c) || v !== 1'b1) begin
          n_err++;
          errs++;
          if (errs < 5)
            $display("FAIL random_read round=%0d col=%0d: data=%h win=%b valid=%b, want %h %b 1",
                     r, c, d, w, v, model_rd_data(c), model_rd_win(c));
        end
      end
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_priority();
    test_transp_window();
    test_read_timing();
    test_abort();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
